// File: rtl/ram_io_bridge.sv
// ram_io_bridge: adapts a byte-addressed load/store request port to a
// word-wide RAM with byte-lane write enables and a one-cycle ready pulse.
// Optional memory-mapped LED register enabled by RAM_IO_BRIDGE_LED_EN.
module ram_io_bridge #(
  parameter int unsigned RamAddressBitWidth = 21,
  parameter logic [31:0] LedAddress         = 32'hFFFF_FFFF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ramio_enable,
  input  logic [1:0]                    ramio_write_type,
  input  logic [2:0]                    ramio_read_type,
  input  logic [31:0]                   ramio_address,
  input  logic [31:0]                   ramio_data_in,
  output logic [31:0]                   ramio_data_out,
  output logic                          ramio_data_out_ready,
  output logic                          ramio_busy,
  output logic                          mem_enable,
  output logic [3:0]                    mem_write_mask,
  output logic [RamAddressBitWidth-3:0] mem_address,
  output logic [31:0]                   mem_data_in,
  input  logic [31:0]                   mem_data_out,
  input  logic                          mem_ready,
  output logic [3:0]                    led,
  output logic                          misaligned
);

  localparam logic [1:0] SizeNone = 2'b00;
  localparam logic [1:0] SizeByte = 2'b01;
  localparam logic [1:0] SizeHalf = 2'b10;
  localparam logic [1:0] SizeWord = 2'b11;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StDone   = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] address;
    logic [2:0]  read_type;
    logic [1:0]  write_type;
  } req_t;

  state_t      state;
  state_t      state_next;
  req_t        cur_req;
  req_t        lat_req;
  logic        lat_valid;
  logic [1:0]  lat_off;
  logic        lat_is_read;

  logic        is_write;
  logic        is_read;
  logic        is_noop;
  logic [1:0]  size;
  logic        misalign_hit;
  logic [1:0]  eff_off;
  logic [3:0]  wmask;
  logic [31:0] wdata;
  logic        led_hit;
  logic        bypass;
  logic        new_req;

  assign cur_req     = {ramio_address, ramio_read_type, ramio_write_type};
  assign is_write    = (ramio_write_type != SizeNone);
  assign is_read     = !is_write && (ramio_read_type[1:0] != SizeNone);
  assign is_noop     = !is_write && !is_read;
  assign lat_is_read = (lat_req.write_type == SizeNone) &&
                       (lat_req.read_type[1:0] != SizeNone);

  // A fresh request is one that differs from the last accepted one
  assign new_req = !rst && ramio_enable && (state != StAccess) &&
                   (!lat_valid || (cur_req != lat_req));

  // LED and no-op requests never touch the RAM
  assign bypass = led_hit || is_noop;

  assign ramio_busy = (state == StAccess) || new_req;

  assign ramio_data_out_ready = (state == StDone) && lat_valid && lat_is_read &&
                                (cur_req == lat_req) && ramio_enable;

  // Access size, effective lane offset, lane mask and replicated write data
  always_comb begin
    size         = SizeNone;
    misalign_hit = 1'b0;
    eff_off      = 2'b00;
    wmask        = 4'b0000;
    wdata        = ramio_data_in;
    size = is_write ? ramio_write_type : ramio_read_type[1:0];
    case (size)
      SizeByte: begin
        eff_off = ramio_address[1:0];
        wmask   = 4'(4'b0001 << eff_off);
        wdata   = {4{ramio_data_in[7:0]}};
      end
      SizeHalf: begin
        misalign_hit = ramio_address[0];
        eff_off      = {ramio_address[1], 1'b0};
        wmask        = 4'(4'b0011 << eff_off);
        wdata        = {2{ramio_data_in[15:0]}};
      end
      SizeWord: begin
        misalign_hit = (ramio_address[1:0] != 2'b00);
        eff_off      = 2'b00;
        wmask        = 4'b1111;
        wdata        = ramio_data_in;
      end
      default: begin
        eff_off = 2'b00;
        wmask   = 4'b0000;
      end
    endcase
    if (!is_write) begin
      wmask = 4'b0000;
    end
  end

  // Lane-select and zero/sign-extend a RAM word for the latched read
  function automatic logic [31:0] extend_read(input logic [31:0] word,
                                              input logic [2:0]  rtype,
                                              input logic [1:0]  off);
    logic [31:0] sh;
    logic [31:0] res;
    sh  = word >> {off, 3'b000};
    res = sh;
    case (rtype[1:0])
      SizeByte: res = rtype[2] ? {{24{sh[7]}}, sh[7:0]} : {24'b0, sh[7:0]};
      SizeHalf: res = rtype[2] ? {{16{sh[15]}}, sh[15:0]} : {16'b0, sh[15:0]};
      default:  res = word;
    endcase
    return res;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= StIdle;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      StIdle, StDone: begin
        if (new_req) begin
          state_next = bypass ? StDone : StAccess;
        end
      end
      StAccess: begin
        if (mem_ready) begin
          state_next = StDone;
        end
      end
      default: state_next = StIdle;
    endcase
  end

  // Request latch, RAM strobe/lanes and read data capture
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_req        <= '0;
      lat_valid      <= 1'b0;
      lat_off        <= 2'b00;
      mem_enable     <= 1'b0;
      mem_write_mask <= 4'b0000;
      mem_address    <= '0;
      mem_data_in    <= '0;
      ramio_data_out <= '0;
      misaligned     <= 1'b0;
    end else if (new_req) begin
      lat_req        <= cur_req;
      lat_valid      <= 1'b1;
      lat_off        <= eff_off;
      mem_enable     <= !bypass;
      mem_write_mask <= bypass ? 4'b0000 : wmask;
      mem_address    <= ramio_address[RamAddressBitWidth-1:2];
      mem_data_in    <= wdata;
      if (misalign_hit) begin
        misaligned <= 1'b1;
      end
      if (led_hit && is_read) begin
        ramio_data_out <= {28'b0, led};
      end
    end else if ((state == StAccess) && mem_ready) begin
      mem_enable     <= 1'b0;
      mem_write_mask <= 4'b0000;
      if (lat_is_read) begin
        ramio_data_out <= extend_read(mem_data_out, lat_req.read_type, lat_off);
      end
    end
  end

`ifdef RAM_IO_BRIDGE_LED_EN
  assign led_hit = (ramio_address == LedAddress);

  // LED register written by a store to LedAddress
  always_ff @(posedge clk) begin
    if (rst) begin
      led <= 4'b0000;
    end else if (new_req && led_hit && is_write) begin
      led <= ramio_data_in[3:0];
    end
  end
`else
  logic unused_led_address;

  assign led_hit            = 1'b0;
  assign led                = 4'b0000;
  assign unused_led_address = ^LedAddress;
`endif

endmodule

// File: doc/ram_io_bridge.md
RAM_IO_BRIDGE -- requirements
Module: ram_io_bridge

Interface
REQ-001 Parameter RamAddressBitWidth, default 21, byte-address width of backing RAM (2 MB).
REQ-002 Parameter LedAddress, default 32'hFFFF_FFFF, byte address of LED register.
REQ-003 Port clk  input  1  sole clock; all logic on rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port ramio_enable  input  1  request present.
REQ-006 Port ramio_write_type  input  2  b00 none, b01 byte, b10 half, b11 word.
REQ-007 Port ramio_read_type  input  3  b000 none; bit2 sign-extend; [1:0] b01 byte, b10 half, b11 word.
REQ-008 Port ramio_address  input  32  byte address.
REQ-009 Port ramio_data_in  input  32  write data, right-aligned.
REQ-010 Port ramio_data_out  output  32  read result, extended per read_type.
REQ-011 Port ramio_data_out_ready  output  1  ramio_data_out valid for current request.
REQ-012 Port ramio_busy  output  1  request not yet complete.
REQ-013 Port mem_enable  output  1  RAM access strobe.
REQ-014 Port mem_write_mask  output  4  byte-lane write enables; 0 = read.
REQ-015 Port mem_address  output  RamAddressBitWidth-2  word address.
REQ-016 Port mem_data_in  output  32  lane-shifted write data.
REQ-017 Port mem_data_out  input  32  RAM read word.
REQ-018 Port mem_ready  input  1  one-cycle pulse: access complete, mem_data_out valid.
REQ-019 Port led  output  4  LED register.
REQ-020 Port misaligned  output  1  sticky misaligned-access flag.

Function
REQ-021 States Idle, Access, Done; request = {ramio_address, ramio_read_type, ramio_write_type}.
REQ-022 New request: ramio_enable=1 and (state=Idle or Done) and request differs from latched completed request (or none completed); accepted same cycle, latched at clock edge, state -> Access.
REQ-023 ramio_busy combinational: high when state=Access or a new request is presented this cycle; low otherwise.
REQ-024 In Access: mem_enable=1 held until mem_ready; mem_address = address[RamAddressBitWidth-1:2]; upper address bits ignored.
REQ-025 Write: mem_write_mask = b0001<<addr[1:0] (byte), b0011<<{addr[1],0} (half), b1111 (word); mem_data_in = data replicated to addressed lane.
REQ-026 Read: mem_write_mask=0; on mem_ready, select lane by addr[1:0], zero- or sign-extend per read_type bit2, register into ramio_data_out.
REQ-027 On mem_ready: mem_enable <= 0, state -> Done.
REQ-028 ramio_data_out_ready combinational: state=Done and latched request is a read and equals current request and ramio_enable=1.
REQ-029 Min read latency: request at cycle N, mem_ready at N+2 -> data_out_ready high at N+3.
REQ-030 Request changes or ramio_enable drops while in Access: ignored; transaction completes on latched request.
REQ-031 Identical request re-presented in Done: no new access; ready stays high.
REQ-032 Misaligned (half with addr[0]=1, word with addr[1:0]!=0): addr low bits treated as 0, access performed, misaligned <= 1 until reset.
REQ-033 Both read_type and write_type nonzero: write takes precedence.

Reset
REQ-034 On rst: state Idle, mem_enable 0, mem_write_mask 0, ramio_data_out 0, led 0, misaligned 0, latched request cleared.
REQ-035 rst mid-Access aborts transaction; late mem_ready after reset ignored.

Configuration
REQ-036 Macro RAM_IO_BRIDGE_LED_EN: defined -> access with ramio_address==LedAddress bypasses RAM (no mem_enable), write sets led <= data_in[3:0], read returns {28'b0, led}, completes in Done next cycle.
REQ-037 Not defined -> led tied 0, LedAddress treated as ordinary RAM address.

Verification
REQ-038 SW 0x1234_5678 @0x10, mem_ready after 1 cycle -> mem_write_mask b1111, busy high request cycle through mem_ready, then low.
REQ-039 SB 0xAB @0x13 -> mem_write_mask b1000, mem_data_in[31:24]=0xAB.
REQ-040 RAM word 0x80FF_7F01; LB @0x2 -> 0xFFFF_FFFF; LBU @0x2 -> 0x0000_00FF; LH @0x2 -> 0xFFFF_80FF.
REQ-041 LW @0x20, address changed to 0x24 mid-Access -> 0x20 completes, ready low, then 0x24 accepted.
REQ-042 LED_EN defined: SB 0x5 @0xFFFF_FFFF -> led=4'h5, no mem_enable; LW @0x2 -> misaligned=1.
REQ-043 rst asserted during Access -> next cycle mem_enable 0, busy 0, ready 0.
